// File: rtl/tc_array_pkg.sv
// rtl/tc_array_pkg.sv - shared register map, CTRL bit positions and channel FSM encoding for tc_array.
package tc_array_pkg;

  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_PRESET = 4'h4;
  localparam logic [3:0] OFF_COUNT  = 4'h8;
  localparam logic [3:0] OFF_PSC    = 4'hC;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_MODE = 1;
  localparam int CTRL_IM   = 3;
  localparam int CTRL_PEND = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } tc_state_t;

  // Bus-side view of a CTRL write; pend here means "write 1 to clear".
  typedef struct packed {
    logic pend;
    logic im;
    logic mode;
    logic en;
  } ctrl_t;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  lanes);
    logic [31:0] mask;
    for (int i = 0; i < 4; i++) mask[i*8 +: 8] = {8{lanes[i]}};
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/tc_channel.sv
// rtl/tc_channel.sv - one timer channel: CTRL/PRESET/COUNT registers, IDLE/LOAD/CNT/INT FSM.
// TC_ARRAY_PRESCALER_EN adds the PSC register and a hidden prescale counter.
module tc_channel
  import tc_array_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_ctrl,
  input  ctrl_t            ctrl_wdata,
  input  logic             wr_preset,
  input  logic [CNT_W-1:0] preset_wdata,
`ifdef TC_ARRAY_PRESCALER_EN
  input  logic             wr_psc,
  input  logic [CNT_W-1:0] psc_wdata,
`endif
  output logic [31:0]      ctrl_rdata,
  output logic [31:0]      preset_rdata,
  output logic [31:0]      count_rdata,
  output logic [31:0]      psc_rdata,
  output logic             irq
);

  tc_state_t        state;
  logic             en_q, mode_q, im_q, pend_q;
  logic [CNT_W-1:0] preset_q, count_q;
  logic             tick;

`ifdef TC_ARRAY_PRESCALER_EN
  logic [CNT_W-1:0] psc_q, psc_cnt;
  assign tick      = (psc_cnt == psc_q);
  assign psc_rdata = 32'(psc_q);
`else
  assign tick      = 1'b1;
  assign psc_rdata = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      en_q     <= 1'b0;
      mode_q   <= 1'b0;
      im_q     <= 1'b0;
      pend_q   <= 1'b0;
      preset_q <= '0;
      count_q  <= '0;
`ifdef TC_ARRAY_PRESCALER_EN
      psc_q    <= '0;
      psc_cnt  <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: if (en_q) state <= ST_LOAD;
        ST_LOAD: begin
          count_q <= preset_q;
`ifdef TC_ARRAY_PRESCALER_EN
          psc_cnt <= '0;
`endif
          state   <= ST_CNT;
        end
        ST_CNT: begin
          if (!en_q) begin
            state <= ST_IDLE;
          end else begin
`ifdef TC_ARRAY_PRESCALER_EN
            psc_cnt <= tick ? '0 : psc_cnt + CNT_W'(1);
`endif
            if (tick) begin
              if (count_q <= CNT_W'(1)) begin
                count_q <= '0;
                state   <= ST_INT;
              end else begin
                count_q <= count_q - CNT_W'(1);
              end
            end
          end
        end
        ST_INT: begin
          pend_q <= 1'b1;
          if (!mode_q) begin
            en_q  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            state <= ST_LOAD;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Bus write overrides the FSM's EN clear, but never swallows a fresh PEND.
      if (wr_ctrl) begin
        en_q   <= ctrl_wdata.en;
        mode_q <= ctrl_wdata.mode;
        im_q   <= ctrl_wdata.im;
        if (ctrl_wdata.pend && state != ST_INT) pend_q <= 1'b0;
      end
      if (wr_preset) preset_q <= preset_wdata;
`ifdef TC_ARRAY_PRESCALER_EN
      if (wr_psc) psc_q <= psc_wdata;
`endif
    end
  end

  always_comb begin
    ctrl_rdata            = '0;
    ctrl_rdata[CTRL_EN]   = en_q;
    ctrl_rdata[CTRL_MODE] = mode_q;
    ctrl_rdata[CTRL_IM]   = im_q;
    ctrl_rdata[CTRL_PEND] = pend_q;
  end

  assign preset_rdata = 32'(preset_q);
  assign count_rdata  = 32'(count_q);
  assign irq          = pend_q & im_q;

endmodule

// File: rtl/tc_array.sv
// rtl/tc_array.sv - NUM_CH-channel timer/counter: window decode, byte-lane write merge, read mux, irq vector.
// TC_ARRAY_PRESCALER_EN enables the per-channel PSC register at offset 0xC.
module tc_array
  import tc_array_pkg::*;
#(
  parameter int          NUM_CH    = 2,
  parameter int          CNT_W     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
  parameter int          CH_STRIDE = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       addr,
  input  logic              we,
  input  logic [3:0]        byteen,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic [NUM_CH-1:0] irq
);

  localparam int          SH  = $clog2(CH_STRIDE);
  localparam logic [31:0] WIN = 32'(NUM_CH * CH_STRIDE);

  logic [31:0] rel, ch_sel;
  logic        mapped;
  logic [3:0]  reg_off;
  ctrl_t       ctrl_wr;

  logic [31:0] ctrl_rd   [NUM_CH];
  logic [31:0] preset_rd [NUM_CH];
  logic [31:0] count_rd  [NUM_CH];
  logic [31:0] psc_rd    [NUM_CH];

  // Only the first 16 bytes of each stride are registers; the rest of the stride is a hole.
  always_comb begin
    rel     = addr - BASE_ADDR;
    ch_sel  = rel >> SH;
    mapped  = (addr >= BASE_ADDR) && (rel < WIN) && ((rel & 32'(CH_STRIDE - 1)) < 32'd16);
    reg_off = rel[3:0];
  end

  always_comb begin
    ctrl_wr      = '0;
    ctrl_wr.en   = wdata[CTRL_EN];
    ctrl_wr.mode = wdata[CTRL_MODE];
    ctrl_wr.im   = wdata[CTRL_IM];
    ctrl_wr.pend = wdata[CTRL_PEND];
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic        hit;
    logic [31:0] preset_mrg;
    assign hit        = mapped && (ch_sel == 32'(g));
    assign preset_mrg = lane_merge(preset_rd[g], wdata, byteen);
`ifdef TC_ARRAY_PRESCALER_EN
    logic [31:0] psc_mrg;
    assign psc_mrg = lane_merge(psc_rd[g], wdata, byteen);
`endif

    tc_channel #(.CNT_W(CNT_W)) u_ch (
      .clk          (clk),
      .reset        (reset),
      .wr_ctrl      (we && hit && reg_off == OFF_CTRL && byteen[0]),
      .ctrl_wdata   (ctrl_wr),
      .wr_preset    (we && hit && reg_off == OFF_PRESET),
      .preset_wdata (preset_mrg[CNT_W-1:0]),
`ifdef TC_ARRAY_PRESCALER_EN
      .wr_psc       (we && hit && reg_off == OFF_PSC),
      .psc_wdata    (psc_mrg[CNT_W-1:0]),
`endif
      .ctrl_rdata   (ctrl_rd[g]),
      .preset_rdata (preset_rd[g]),
      .count_rdata  (count_rd[g]),
      .psc_rdata    (psc_rd[g]),
      .irq          (irq[g])
    );
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (mapped && ch_sel == 32'(i)) begin
        case (reg_off)
          OFF_CTRL:   rdata = ctrl_rd[i];
          OFF_PRESET: rdata = preset_rd[i];
          OFF_COUNT:  rdata = count_rd[i];
          OFF_PSC:    rdata = psc_rd[i];
          default:    rdata = '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tc_array.sv
// tb/tb_tc_array.sv - directed self-checking bench for tc_array (2 channels, base 0x7F00).
module tb_tc_array;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [1:0]  irq;

  int checks = 0;
  int errors = 0;

  tc_array dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .we     (we),
    .byteen (byteen),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    addr = a; wdata = d; byteen = be; we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0; byteen = 4'h0;
  endtask

  task automatic read_reg(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [31:0] regs [6];
    regs = '{32'h7F00, 32'h7F04, 32'h7F08, 32'h7F10, 32'h7F14, 32'h7F18};
    reset = 1'b1; we = 1'b0; addr = '0; wdata = '0; byteen = '0;
    step(3);
    reset = 1'b0;
    checks++;
    if (irq !== 2'b00) begin errors++; $display("FAIL reset_irq got=%b exp=00", irq); end
    for (int i = 0; i < 6; i++) begin
      read_reg(regs[i], d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL reset_reg addr=%h got=%h exp=0", regs[i], d); end
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    bus_write(32'h7F04, 32'd5, 4'hF);
    bus_write(32'h7F00, 32'h09, 4'hF);
    step(7);
    checks++;
    if (irq !== 2'b00) begin errors++; $display("FAIL oneshot_early got=%b exp=00", irq); end
    step(1);
    checks++;
    if (irq !== 2'b01) begin errors++; $display("FAIL oneshot_irq got=%b exp=01", irq); end
    read_reg(32'h7F00, d);
    checks++;
    if (d !== 32'h18) begin errors++; $display("FAIL oneshot_ctrl got=%h exp=18", d); end
    read_reg(32'h7F08, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL oneshot_count got=%h exp=0", d); end
    bus_write(32'h7F00, 32'h10, 4'h1);
    checks++;
    if (irq !== 2'b00) begin errors++; $display("FAIL oneshot_clear got=%b exp=00", irq); end
  endtask

  task automatic test_autoreload();
    logic [31:0] d;
    bus_write(32'h7F04, 32'd3, 4'hF);
    bus_write(32'h7F00, 32'h0B, 4'hF);
    step(5);
    checks++;
    if (irq !== 2'b00) begin errors++; $display("FAIL auto_first_early got=%b exp=00", irq); end
    step(1);
    checks++;
    if (irq !== 2'b01) begin errors++; $display("FAIL auto_first got=%b exp=01", irq); end
    for (int k = 0; k < 2; k++) begin
      bus_write(32'h7F00, 32'h1B, 4'h1);
      checks++;
      if (irq !== 2'b00) begin errors++; $display("FAIL auto_clear%0d got=%b exp=00", k, irq); end
      step(3);
      checks++;
      if (irq !== 2'b00) begin errors++; $display("FAIL auto_period_early%0d got=%b exp=00", k, irq); end
      step(1);
      checks++;
      if (irq !== 2'b01) begin errors++; $display("FAIL auto_period%0d got=%b exp=01", k, irq); end
    end
    bus_write(32'h7F00, 32'h10, 4'h1);
    step(3);
    read_reg(32'h7F00, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL auto_stop_ctrl got=%h exp=0", d); end
  endtask

  task automatic test_irq_mask();
    logic [31:0] d;
    bus_write(32'h7F14, 32'd1, 4'hF);
    bus_write(32'h7F10, 32'h01, 4'hF);
    step(5);
    checks++;
    if (irq !== 2'b00) begin errors++; $display("FAIL mask_irq got=%b exp=00", irq); end
    read_reg(32'h7F10, d);
    checks++;
    if (d !== 32'h10) begin errors++; $display("FAIL mask_ctrl got=%h exp=10", d); end
    bus_write(32'h7F10, 32'h08, 4'h1);
    checks++;
    if (irq !== 2'b10) begin errors++; $display("FAIL mask_unmask got=%b exp=10", irq); end
    bus_write(32'h7F10, 32'h10, 4'h1);
    checks++;
    if (irq !== 2'b00) begin errors++; $display("FAIL mask_clear got=%b exp=00", irq); end
  endtask

  task automatic test_disable_preset();
    logic [31:0] d;
    bus_write(32'h7F04, 32'd10, 4'hF);
    bus_write(32'h7F00, 32'h01, 4'hF);
    step(5);
    bus_write(32'h7F04, 32'd4, 4'hF);
    read_reg(32'h7F08, d);
    checks++;
    if (d !== 32'd6) begin errors++; $display("FAIL dis_midcount got=%0d exp=6", d); end
    step(3);
    read_reg(32'h7F08, d);
    checks++;
    if (d !== 32'd3) begin errors++; $display("FAIL dis_count3 got=%0d exp=3", d); end
    bus_write(32'h7F00, 32'h00, 4'hF);
    step(3);
    read_reg(32'h7F08, d);
    checks++;
    if (d !== 32'd2) begin errors++; $display("FAIL dis_frozen got=%0d exp=2", d); end
    checks++;
    if (irq !== 2'b00) begin errors++; $display("FAIL dis_irq got=%b exp=00", irq); end
    bus_write(32'h7F08, 32'h77, 4'hF);
    read_reg(32'h7F08, d);
    checks++;
    if (d !== 32'd2) begin errors++; $display("FAIL count_ro got=%0d exp=2", d); end
    bus_write(32'h7F00, 32'h09, 4'hF);
    step(2);
    read_reg(32'h7F08, d);
    checks++;
    if (d !== 32'd4) begin errors++; $display("FAIL reload_new_preset got=%0d exp=4", d); end
    step(4);
    checks++;
    if (irq !== 2'b00) begin errors++; $display("FAIL reen_early got=%b exp=00", irq); end
    step(1);
    checks++;
    if (irq !== 2'b01) begin errors++; $display("FAIL reen_irq got=%b exp=01", irq); end
    bus_write(32'h7F00, 32'h10, 4'h1);
  endtask

  task automatic test_byte_lanes();
    logic [31:0] d;
    bus_write(32'h7F14, 32'h0, 4'hF);
    bus_write(32'h7F14, 32'hAABBCCDD, 4'b0010);
    read_reg(32'h7F14, d);
    checks++;
    if (d !== 32'h0000CC00) begin errors++; $display("FAIL lane_preset got=%h exp=0000cc00", d); end
    read_reg(32'h7F04, d);
    checks++;
    if (d !== 32'd4) begin errors++; $display("FAIL lane_ch0 got=%h exp=4", d); end
    bus_write(32'h7F10, 32'hFF, 4'b0010);
    read_reg(32'h7F10, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL lane_ctrl got=%h exp=0", d); end
    bus_write(32'h7F20, 32'h12345678, 4'hF);
    read_reg(32'h7F20, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL outside_read got=%h exp=0", d); end
    read_reg(32'h7F04, d);
    checks++;
    if (d !== 32'd4) begin errors++; $display("FAIL outside_alias got=%h exp=4", d); end
    read_reg(32'h7F05, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL unaligned got=%h exp=0", d); end
  endtask

  task automatic test_prescaler_reset();
    logic [31:0] d;
    logic [31:0] regs [5];
    regs = '{32'h7F00, 32'h7F04, 32'h7F08, 32'h7F10, 32'h7F14};
`ifdef TC_ARRAY_PRESCALER_EN
    bus_write(32'h7F0C, 32'd3, 4'hF);
    read_reg(32'h7F0C, d);
    checks++;
    if (d !== 32'd3) begin errors++; $display("FAIL psc_read got=%h exp=3", d); end
    bus_write(32'h7F04, 32'd2, 4'hF);
    bus_write(32'h7F00, 32'h09, 4'hF);
    step(5);
    read_reg(32'h7F08, d);
    checks++;
    if (d !== 32'd2) begin errors++; $display("FAIL psc_hold got=%0d exp=2", d); end
    step(1);
    read_reg(32'h7F08, d);
    checks++;
    if (d !== 32'd1) begin errors++; $display("FAIL psc_dec got=%0d exp=1", d); end
    step(4);
    checks++;
    if (irq !== 2'b00) begin errors++; $display("FAIL psc_early got=%b exp=00", irq); end
    step(1);
    checks++;
    if (irq !== 2'b01) begin errors++; $display("FAIL psc_irq got=%b exp=01", irq); end
    bus_write(32'h7F00, 32'h10, 4'h1);
    bus_write(32'h7F0C, 32'd0, 4'hF);
`else
    bus_write(32'h7F0C, 32'd5, 4'hF);
    read_reg(32'h7F0C, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL psc_absent got=%h exp=0", d); end
`endif
    bus_write(32'h7F14, 32'd0, 4'hF);
    bus_write(32'h7F04, 32'd20, 4'hF);
    bus_write(32'h7F00, 32'h0B, 4'hF);
    bus_write(32'h7F10, 32'h09, 4'hF);
    step(5);
    checks++;
    if (irq !== 2'b10) begin errors++; $display("FAIL rst_pre_irq got=%b exp=10", irq); end
    read_reg(32'h7F08, d);
    checks++;
    if (d !== 32'd16) begin errors++; $display("FAIL rst_pre_count got=%0d exp=16", d); end
    @(negedge clk);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    checks++;
    if (irq !== 2'b00) begin errors++; $display("FAIL rst_irq got=%b exp=00", irq); end
    for (int i = 0; i < 5; i++) begin
      read_reg(regs[i], d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL rst_reg addr=%h got=%h exp=0", regs[i], d); end
    end
    step(4);
    read_reg(32'h7F08, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL rst_idle_count got=%h exp=0", d); end
    checks++;
    if (irq !== 2'b00) begin errors++; $display("FAIL rst_idle_irq got=%b exp=00", irq); end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_autoreload();
    test_irq_mask();
    test_disable_preset();
    test_byte_lanes();
    test_prescaler_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
